// File: rtl/efp_add_arbiter.sv
// Round-robin scheduler sharing one EFP LUT adder among NUM_REQ requesters.
// Sequences the adder flag/cal_over handshake, with stale-done rejection and timeout abort.
module efp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*5-1:0]     req_mbit1,
    input  logic [NUM_REQ*5-1:0]     req_mbit2,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic [4:0]               add_mbit1,
    output logic [4:0]               add_mbit2,
    output logic                     add_flag,
    input  logic                     add_cal_over,
    input  logic                     add_sign,
    input  logic [5:0]               add_exp,
    input  logic [8:0]               add_man,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2:0]               rsp_id,
    output logic [15:0]              rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      rr_ptr;
    logic [CW-1:0]   wait_cnt;

    logic            grant_found;
    logic [2:0]      grant_idx;
    logic [2:0]      scan_idx;
    logic [7:0]      valid_pad;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [4:0]      sel_mbit1;
    logic [4:0]      sel_mbit2;
    logic            cal_ok;
    logic            run_done;

    // Search starts one past the last winner so a held request cannot starve others.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        valid_pad   = 8'(req_valid);
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = 3'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && valid_pad[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_mbit1 = '0;
        sel_mbit2 = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_a     = req_a[i*WIDTH +: WIDTH];
                sel_b     = req_b[i*WIDTH +: WIDTH];
                sel_mbit1 = req_mbit1[i*5 +: 5];
                sel_mbit2 = req_mbit2[i*5 +: 5];
                req_ready[i] = (state == IDLE) && !rst && grant_found;
            end
        end
    end

    // cal_over in the first RUN cycle is left over from the previous operation.
    assign cal_ok   = (wait_cnt != '0) && add_cal_over;
    assign run_done = cal_ok || (wait_cnt == LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_found) state_nx = RUN;
            RUN:     if (run_done)    state_nx = RESP;
            RESP:    if (rsp_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_a     <= '0;
            add_b     <= '0;
            add_mbit1 <= '0;
            add_mbit2 <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
            rr_ptr    <= 3'(NUM_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        add_a     <= sel_a;
                        add_b     <= sel_b;
                        add_mbit1 <= sel_mbit1;
                        add_mbit2 <= sel_mbit2;
                        rsp_id    <= grant_idx;
                        rr_ptr    <= grant_idx;
                        wait_cnt  <= '0;
                    end
                end
                RUN: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (cal_ok) begin
                        rsp_data <= {add_sign, add_exp, add_man};
                        rsp_err  <= 1'b0;
                    end else if (wait_cnt == LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_flag  = (state == RUN);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_efp_add_arbiter.sv
// Scoreboard bench for efp_add_arbiter with a behavioural EFP adder timing model.
// Expected grants come from a round-robin model; expected results from the adder model.
module tb_efp_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*5-1:0]     req_mbit1;
    logic [NUM_REQ*5-1:0]     req_mbit2;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [4:0]               add_mbit1;
    logic [4:0]               add_mbit2;
    logic                     add_flag;
    logic                     add_cal_over;
    logic                     add_sign;
    logic [5:0]               add_exp;
    logic [8:0]               add_man;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [2:0]               rsp_id;
    logic [15:0]              rsp_data;
    logic                     rsp_err;
    logic                     busy;

    efp_add_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mbit1(req_mbit1), .req_mbit2(req_mbit2),
        .add_a(add_a), .add_b(add_b), .add_mbit1(add_mbit1), .add_mbit2(add_mbit2),
        .add_flag(add_flag), .add_cal_over(add_cal_over),
        .add_sign(add_sign), .add_exp(add_exp), .add_man(add_man),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [15:0] op_a  [NUM_REQ];
    logic [15:0] op_b  [NUM_REQ];
    logic [4:0]  op_m1 [NUM_REQ];
    logic [4:0]  op_m2 [NUM_REQ];

    always_comb begin
        req_a     = '0;
        req_b     = '0;
        req_mbit1 = '0;
        req_mbit2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
            req_mbit1[i*5 +: 5]     = op_m1[i];
            req_mbit2[i*5 +: 5]     = op_m2[i];
        end
    end

    function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
        return (a[14:0] == 15'd0) || (b[14:0] == 15'd0) || ((a ^ b) == 16'h8000);
    endfunction

    // Stand-in adder arithmetic: zero operand passes the other through, cancellation gives 0.
    function automatic logic [15:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                              input logic [4:0] m1, input logic [4:0] m2);
        if (a[14:0] == 15'd0) return b;
        if (b[14:0] == 15'd0) return a;
        if ((a ^ b) == 16'h8000) return 16'h0000;
        return a + b + 16'({m1, m2});
    endfunction

    // Adder timing: cal_over rises in RUN cycle 3 (normal) or 1 (special) and stays high
    // until the first cycle of the next operation, which is what makes it stale there.
    int   mcnt  = 0;
    logic mdone = 1'b0;
    bit   hang  = 1'b0;

    always @(posedge clk) begin
        if (add_flag) begin
            mcnt <= mcnt + 1;
            if (mcnt == 0) mdone <= 1'b0;
            if (!hang && mcnt == (is_special(add_a, add_b) ? 0 : 2)) mdone <= 1'b1;
        end else begin
            mcnt <= 0;
        end
    end

    assign add_cal_over = mdone;
    assign {add_sign, add_exp, add_man} = model_res(add_a, add_b, add_mbit1, add_mbit2);

    typedef struct {
        logic [2:0]  id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_ptr = NUM_REQ - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One operation end to end; entered and left just after a rising edge with the DUT idle.
    task automatic run_op(input logic [NUM_REQ-1:0] mask, input bit hold, input int stall,
                          output logic [2:0] got_id);
        int   g;
        int   n;
        int   fc;
        int   exp_lat;
        exp_t e;
        g = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (g < 0 && mask[(model_ptr + k) % NUM_REQ]) g = (model_ptr + k) % NUM_REQ;
        end
        e.id = 3'(g);
        if (hang) begin
            e.data  = 16'h0000;
            e.err   = 1'b1;
            exp_lat = TIMEOUT;
        end else begin
            e.data  = model_res(op_a[g], op_b[g], op_m1[g], op_m2[g]);
            e.err   = 1'b0;
            exp_lat = is_special(op_a[g], op_b[g]) ? 2 : 4;
        end
        sb.push_back(e);
        got_id    = '0;
        rsp_ready = (stall == 0);
        req_valid = mask;

        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("grant", 32'(req_ready), 32'(4'b0001 << g));
        if (req_ready == '0) begin
            void'(sb.pop_back());
            req_valid = '0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) req_valid = '0;
        model_ptr = g;

        n  = 0;
        fc = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            fc += int'(add_flag);
            n++;
            @(negedge clk);
        end
        check("latency", n, exp_lat);
        check("flag_cycles", fc, exp_lat);
        e = sb.pop_front();
        if (!rsp_valid) begin
            rsp_ready = 1'b1;
            return;
        end
        got_id = rsp_id;
        check("rsp_id", rsp_id, e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", rsp_err, e.err);
        check("flag_in_resp", add_flag, 1'b0);

        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_no_grant", 32'(req_ready), 0);
            check("stall_data", rsp_data, e.data);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_after_resp", rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] gid;
        int         cnt [NUM_REQ];

        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i]  = 16'h3C00 + 16'(i << 4);
            op_b[i]  = 16'h4200 + 16'(i);
            op_m1[i] = 5'(i + 1);
            op_m2[i] = 5'(i + 2);
            cnt[i]   = 0;
        end
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_add_flag", add_flag, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_id", rsp_id, 3'd0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_add_a", add_a, 16'h0000);
        check("rst_add_mbit", {add_mbit1, add_mbit2}, 10'd0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Normal op from requester 0.
        op_a[0] = 16'h3E40; op_b[0] = 16'h3E40; op_m1[0] = 5'd1; op_m2[0] = 5'd1;
        run_op(4'b0001, 1'b0, 0, gid);

        // Zero operand: short path, result is the other operand.
        op_a[1] = 16'h0000; op_b[1] = 16'hBE00;
        run_op(4'b0010, 1'b0, 0, gid);

        // Stale cal_over from the special op is present in RUN cycle 0 of this one.
        run_op(4'b0100, 1'b0, 0, gid);

        // Exact cancellation special case.
        op_a[3] = 16'h4321; op_b[3] = 16'hC321;
        run_op(4'b1000, 1'b0, 0, gid);

        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = 16'h3C00 + 16'(i << 4);
            op_b[i] = 16'h4200 + 16'(i);
        end
        for (int r = 0; r < 12; r++) begin
            run_op(4'b1111, 1'b1, 0, gid);
            cnt[gid]++;
        end
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) check($sformatf("rr_count%0d", i), cnt[i], 3);

        hang = 1'b1;
        run_op(4'b0010, 1'b0, 0, gid);
        hang = 1'b0;
        run_op(4'b0010, 1'b0, 0, gid);

        // Consumer back-pressure with a competing request pending.
        run_op(4'b0011, 1'b1, 3, gid);
        req_valid = '0;
        @(posedge clk); #1;

        // Reset in RUN cycle 2.
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 4'b0101;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_flag", add_flag, 1'b0);
        check("rst_mid_valid", rsp_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        req_valid = '0;
        @(posedge clk); #1;
        rst       = 1'b0;
        model_ptr = NUM_REQ - 1;
        sb.delete();
        run_op(4'b0101, 1'b0, 0, gid);
        run_op(4'b0100, 1'b0, 0, gid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
